// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined WIDTH x WIDTH Urdhva-Tiryagbhyam multiplier with valid/ready
// handshake and a sideband tag carried alongside every operand pair.
// Stage 1 registers the operands, stage 2 holds every 4x4 leaf product, and each later
// stage merges groups of four sub-products into products of twice the operand width.
// Leaf products are stored in Morton (bit-interleaved) order. Because of this, every
// group of four consecutive entries is always {LL, LH, HL, HH} at each level.
// Optional feature: define VEDIC_MULT_SIGNED_EN to add the in_signed port, which
// selects two's-complement operands.
module vedic_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef VEDIC_MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int LEVELS = $clog2(WIDTH / 4);
    localparam int LAT    = 2 + LEVELS;
    localparam int DIGITS = WIDTH / 4;
    localparam int NLEAF  = DIGITS * DIGITS;

    // Extract the operand digit index from a Morton leaf index (off=1: a digit, off=0: b digit)
    function automatic int digit_of(input int idx, input int off);
        int r;
        r = 0;
        for (int t = 0; t < 8; t++) begin
            r = r | (((idx >> (2 * t + off)) & 1) << t);
        end
        return r;
    endfunction

    logic               adv;
    logic [LAT-1:0]     vld;
    logic [TAG_W-1:0]   tag_q [LAT];
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_final;
    logic [7:0]         leaf_d [NLEAF];
    logic [7:0]         leaf [NLEAF];

    // A single global enable moves every stage together; in_ready only depends on the output side.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LAT-1];
    assign out_tag   = tag_q[LAT-1];

`ifdef VEDIC_MULT_SIGNED_EN
    logic           sign_in;
    logic [LAT-2:0] sign_q;

    // Convert signed operands to magnitudes; the product sign travels down the pipe.
    always_comb begin
        a_mag   = a;
        b_mag   = b;
        sign_in = 1'b0;
        if (in_signed) begin
            if (a[WIDTH-1]) a_mag = -a;
            if (b[WIDTH-1]) b_mag = -b;
            sign_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    // Sign bit pipeline; it only needs to reach the stage that feeds the final register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= '0;
        end else if (adv) begin
            sign_q[0] <= sign_in;
            for (int s = 1; s < LAT - 1; s++) begin
                sign_q[s] <= sign_q[s-1];
            end
        end
    end

    assign neg_final = sign_q[LAT-2];
`else
    assign a_mag     = a;
    assign b_mag     = b;
    assign neg_final = 1'b0;
`endif

    // Stage 1: operand registers plus the valid and tag shift chains for all stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            a_q      <= a_mag;
            b_q      <= b_mag;
            vld      <= {vld[LAT-2:0], in_valid};
            tag_q[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Exact 8-bit product of each 4-bit digit pair, laid out in Morton order.
    always_comb begin
        for (int n = 0; n < NLEAF; n++) begin
            leaf_d[n] = {4'b0, a_q[4*digit_of(n, 1) +: 4]} * {4'b0, b_q[4*digit_of(n, 0) +: 4]};
        end
    end

    // Stage 2: leaf product registers. At WIDTH=4 this is also the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NLEAF; n++) begin
                leaf[n] <= '0;
            end
        end else if (adv) begin
            for (int n = 0; n < NLEAF; n++) begin
                leaf[n] <= (LEVELS == 0 && neg_final) ? -leaf_d[n] : leaf_d[n];
            end
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int  H     = 2 << k;
        localparam int  NOUT  = NLEAF >> (2 * k);
        localparam bit  FINAL = (k == LEVELS);

        logic [2*H-1:0] src  [4*NOUT];
        logic [4*H-1:0] comb [NOUT];
        logic [4*H-1:0] prod [NOUT];

        // Merge four HxH sub-products into one 2Hx2H product.
        // The middle column is reduced with two carry-save layers and then a single adder.
        function automatic logic [4*H-1:0] combine(input logic [2*H-1:0] ll,
                                                   input logic [2*H-1:0] lh,
                                                   input logic [2*H-1:0] hl,
                                                   input logic [2*H-1:0] hh);
            logic [2*H+1:0] x0, x1, x2, x3, s1, c1, s2, c2, mid;
            logic [H-1:0]   top;
            x0  = {2'b0, {H{1'b0}}, ll[2*H-1:H]};
            x1  = {2'b0, lh};
            x2  = {2'b0, hl};
            x3  = {2'b0, hh[H-1:0], {H{1'b0}}};
            s1  = x0 ^ x1 ^ x2;
            c1  = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;
            s2  = s1 ^ c1 ^ x3;
            c2  = ((s1 & c1) | (s1 & x3) | (c1 & x3)) << 1;
            mid = s2 + c2;
            top = hh[2*H-1:H] + {{(H-2){1'b0}}, mid[2*H+1:2*H]};
            return {top, mid[2*H-1:0], ll[H-1:0]};
        endfunction

        if (k == 1) begin : g_src
            assign src = leaf;
        end else begin : g_src
            assign src = g_lvl[k-1].prod;
        end

        // Combinational recombination of each group of four sub-products.
        always_comb begin
            for (int g = 0; g < NOUT; g++) begin
                comb[g] = combine(src[4*g], src[4*g+1], src[4*g+2], src[4*g+3]);
            end
        end

        // Level register. The last level applies the sign and drives y.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int g = 0; g < NOUT; g++) begin
                    prod[g] <= '0;
                end
            end else if (adv) begin
                for (int g = 0; g < NOUT; g++) begin
                    prod[g] <= (FINAL && neg_final) ? -comb[g] : comb[g];
                end
            end
        end
    end

    if (LEVELS == 0) begin : g_out
        assign y = leaf[0];
    end else begin : g_out
        assign y = g_lvl[LEVELS].prod[0];
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed tests for vedic_mult_pipe at WIDTH=16 (LAT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with VEDIC_MULT_SIGNED_EN defined to also exercise the signed mode.
module tb_vedic_mult_pipe;
    localparam int WIDTH = 16;
    localparam int TAG_W = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [3:0]  out_tag;
`ifdef VEDIC_MULT_SIGNED_EN
    logic        in_signed;
`endif

    int checks;
    int errors;

    vedic_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
`ifdef VEDIC_MULT_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        bit seen;
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h0002; in_tag = 4'hA; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL reset_y: got %h want 00000000", y); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("[TB] FAIL reset_tag: got %h want 0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL reset_input_ignored: got out_valid=1 want none"); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic expv;
        out_ready = 1'b1;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; in_tag = 4'h3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            expv = (c == 4);
            checks++;
            if (out_valid !== expv) begin errors++; $display("[TB] FAIL single_latency c=%0d: got out_valid=%b want %b", c, out_valid, expv); end
            if (c == 4) begin
                checks++; if (y !== 32'hFFFE0001) begin errors++; $display("[TB] FAIL single_y: got %h want fffe0001", y); end
                checks++; if (out_tag !== 4'h3) begin errors++; $display("[TB] FAIL single_tag: got %h want 3", out_tag); end
            end
        end
    endtask

    task automatic test_stream();
        int sent, got, first;
        bit seen;
        logic [31:0] expy;
        sent = 0; got = 0; first = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (sent < 8) begin
                in_valid = 1'b1; a = 16'(sent); b = 16'h1000 + 16'(sent); in_tag = 4'(sent);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                expy = 32'(got) * (32'h1000 + 32'(got));
                checks++;
                if (y !== expy || out_tag !== 4'(got)) begin
                    errors++; $display("[TB] FAIL stream_result %0d: got y=%h tag=%h want y=%h tag=%h", got, y, out_tag, expy, 4'(got));
                end
                if (first < 0) first = c;
                checks++;
                if (c != first + got) begin errors++; $display("[TB] FAIL stream_gap %0d: got cycle %0d want %0d", got, c, first + got); end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 8) begin errors++; $display("[TB] FAIL stream_count: got %0d want 8", got); end
        checks++; if (first != 3) begin errors++; $display("[TB] FAIL stream_latency: got first at %0d want 3", first); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL stream_extra: got extra output want none"); end
    endtask

    task automatic test_backpressure();
        int sent, got, stall_left;
        bit holding, seen;
        logic [31:0] hold_y, expy;
        logic [3:0]  hold_tag;
        sent = 0; got = 0; stall_left = 3; holding = 1'b0;
        hold_y = '0; hold_tag = '0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (out_valid === 1'b1 && stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (out_valid === 1'b1 && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
                if (holding) begin
                    checks++;
                    if (y !== hold_y || out_tag !== hold_tag) begin errors++; $display("[TB] FAIL bp_stable: got y=%h tag=%h want y=%h tag=%h", y, out_tag, hold_y, hold_tag); end
                end
                hold_y = y; hold_tag = out_tag; holding = 1'b1;
            end else if (out_valid === 1'b1) begin
                if (holding) begin
                    checks++;
                    if (y !== hold_y || out_tag !== hold_tag) begin errors++; $display("[TB] FAIL bp_release_stable: got y=%h tag=%h want y=%h tag=%h", y, out_tag, hold_y, hold_tag); end
                end
                holding = 1'b0;
                expy = {16'b0, 16'hA000 + 16'(got)} * {16'b0, 16'h00C3 + 16'(got)};
                checks++;
                if (y !== expy || out_tag !== 4'(8 + got)) begin
                    errors++; $display("[TB] FAIL bp_result %0d: got y=%h tag=%h want y=%h tag=%h", got, y, out_tag, expy, 4'(8 + got));
                end
                got++;
            end
            if (sent < 6) begin
                in_valid = 1'b1; a = 16'hA000 + 16'(sent); b = 16'h00C3 + 16'(sent); in_tag = 4'(8 + sent);
                if (in_ready === 1'b1) sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d want 6", got); end
        checks++; if (stall_left != 0) begin errors++; $display("[TB] FAIL bp_stall_taken: got %0d stalls left want 0", stall_left); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL bp_extra: got extra output want none"); end
    endtask

    task automatic test_reset_midflight();
        bit seen, found;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a = 16'(k + 7); b = 16'(k + 9); in_tag = 4'(k + 1);
            @(negedge clk);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_y: got %h want 00000000", y); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL mid_reset_flushed: got stale output want none"); end
        in_valid = 1'b1; a = 16'h0003; b = 16'h0005; in_tag = 4'h6;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (out_valid === 1'b1) begin
                found = 1'b1;
                checks++; if (y !== 32'h0000000F) begin errors++; $display("[TB] FAIL mid_new_y: got %h want 0000000f", y); end
                checks++; if (out_tag !== 4'h6) begin errors++; $display("[TB] FAIL mid_new_tag: got %h want 6", out_tag); end
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL mid_new_timeout: got no output want one"); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] q_y [$];
        logic [3:0]  q_tag [$];
        logic [31:0] ey;
        logic [3:0]  et;
        int sent, got, shown;
        bit seen;
        sent = 0; got = 0; shown = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (q_y.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_extra: got y=%h tag=%h want no output", y, out_tag);
                end else begin
                    ey = q_y.pop_front(); et = q_tag.pop_front();
                    if (y !== ey || out_tag !== et) begin
                        errors++;
                        if (shown < 10) begin
                            shown++; $display("[TB] FAIL rand_result %0d: got y=%h tag=%h want y=%h tag=%h", got, y, out_tag, ey, et);
                        end
                    end
                end
                got++;
            end
            if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                case ($urandom_range(0, 9))
                    0: a = 16'hFFFF;
                    1: a = 16'h0000;
                    default: a = 16'($urandom);
                endcase
                case ($urandom_range(0, 9))
                    0: b = 16'hFFFF;
                    1: b = 16'h0001;
                    default: b = 16'($urandom);
                endcase
                in_tag = 4'(sent);
                if (in_ready === 1'b1) begin
                    q_y.push_back({16'b0, a} * {16'b0, b});
                    q_tag.push_back(4'(sent));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 1000) begin errors++; $display("[TB] FAIL rand_count: got %0d want 1000", got); end
        checks++; if (q_y.size() != 0) begin errors++; $display("[TB] FAIL rand_lost: got %0d pending want 0", q_y.size()); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL rand_dup: got extra output want none"); end
    endtask

`ifdef VEDIC_MULT_SIGNED_EN
    task automatic test_signed();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vs [3];
        logic [31:0] vy [3];
        int sent, got;
        va[0] = 16'hFFFE; vb[0] = 16'h0003; vs[0] = 1'b1; vy[0] = 32'hFFFFFFFA;
        va[1] = 16'h8000; vb[1] = 16'h8000; vs[1] = 1'b1; vy[1] = 32'h40000000;
        va[2] = 16'hFFFE; vb[2] = 16'h0003; vs[2] = 1'b0; vy[2] = 32'h0002FFFA;
        sent = 0; got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (sent < 3) begin
                in_valid = 1'b1; a = va[sent]; b = vb[sent]; in_signed = vs[sent]; in_tag = 4'(sent + 12);
                sent++;
            end else begin
                in_valid = 1'b0; in_signed = 1'b0;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (y !== vy[got] || out_tag !== 4'(got + 12)) begin
                    errors++; $display("[TB] FAIL signed_result %0d: got y=%h tag=%h want y=%h tag=%h", got, y, out_tag, vy[got], 4'(got + 12));
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 3) begin errors++; $display("[TB] FAIL signed_count: got %0d want 3", got); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
`ifdef VEDIC_MULT_SIGNED_EN
        in_signed = 1'b0;
`endif
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_random();
`ifdef VEDIC_MULT_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
